ps_pcstck_ctrl: RTL

PS_PCSTCK_CTRL -- requirements
Module: ps_pcstck_ctrl

---
 rtl/ps_pcstck_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/ps_pcstck_ctrl.sv
// PC stack controller: ureg-mapped push/pop LIFO with zero-latency top-of-stack
// read, saturating entry count and sticky overflow/underflow flags.
module ps_pcstck_ctrl #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ps_wrt_en,
    input  logic [4:0]                 ps_wrt_add,
    input  logic [WIDTH-1:0]           ps_wrt_dat,
    input  logic                       ps_pop,
    input  logic                       ps_stat_clr,
    output logic [WIDTH-1:0]           ps_tos,
    output logic [$clog2(DEPTH):0]     ps_sp,
    output logic                       ps_stck_empty,
    output logic                       ps_stck_full,
    output logic                       ps_stck_ovf,
    output logic                       ps_stck_unf
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned SPW = AW + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
    localparam logic [4:0]     PS_ADDR = 5'b00100;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SPW-1:0]   sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             push;
    logic             empty;
    logic             full;
    logic [AW-1:0]    top_idx;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;

    assign push    = ps_wrt_en && (ps_wrt_add == PS_ADDR);
    assign empty   = (sp_q == '0);
    assign full    = (sp_q == SP_FULL);
    assign top_idx = AW'(sp_q - 1'b1);

    always_comb begin
        sp_d   = sp_q;
        ovf_d  = ovf_q & ~ps_stat_clr;
        unf_d  = unf_q & ~ps_stat_clr;
        wr_en  = 1'b0;
        wr_idx = AW'(sp_q);
        unique case ({push, ps_pop})
            2'b10: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en = 1'b1;
                    sp_d  = sp_q + 1'b1;
                end
            end
            2'b01: begin
                if (empty) unf_d = 1'b1;
                else       sp_d  = sp_q - 1'b1;
            end
            2'b11: begin
                // Simultaneous push/pop replaces the top; on empty it degenerates
                // to a push into slot 0 while still flagging the underflowing pop.
                wr_en = 1'b1;
                if (empty) begin
                    wr_idx = '0;
                    sp_d   = SPW'(1);
                    unf_d  = 1'b1;
                end else begin
                    wr_idx = top_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Storage is not reset; gating on rst keeps a held reset from writing it.
    always_ff @(posedge clk) begin
        if (wr_en && rst) mem_q[wr_idx] <= ps_wrt_dat;
    end

    assign ps_tos        = empty ? '0 : mem_q[top_idx];
    assign ps_sp         = sp_q;
    assign ps_stck_empty = empty;
    assign ps_stck_full  = full;
    assign ps_stck_ovf   = ovf_q;
    assign ps_stck_unf   = unf_q;

endmodule
